uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame timing and receiver state encoding.
package uart_pkg;

  // 50 MHz / 115200 baud; the transmitter and baud logic use the same value.
  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Latency: 2 cycles. Backpressure: none.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver sampling mid-bit from an internal baud counter on clk_50m.
// Latency: valid 2 + HALF + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the start edge.
// Backpressure: single holding register; an unconsumed byte is overwritten and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_50m (clk_50m),
    .rst     (rst),
    .d       (rxd),
    .q       (rxd_s)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxd_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (rxd_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              data    <= shreg;
              valid   <= 1'b1;
              overrun <= valid && !ready;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Hold here while the line stays low so a break is not decoded as 0x00 frames.
        BREAK: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model with a per-cycle handshake checker.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 434;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + (UART_DATA_BITS + 1) * CPB + 1;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       rxd     = 1'b1;
  logic       ready   = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_ovr    = 0;
  int  n_ferr   = 0;
  bit  rnd_ready = 1'b0;
  logic ready_req = 1'b1;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         t;
  } ev_t;

  ev_t exp_q[$];
  int  evt_cyc[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial forever #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk_50m);
    #2;
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one frame starting at the current negedge; start edge cycle sets the expected event time.
  task automatic send_frame(input logic [7:0] b, input int baud, input bit stop_ok, input int abort_bit);
    ev_t         e;
    logic [9:0]  bits;
    bits     = {stop_ok, b, 1'b0};
    e.is_err = !stop_ok;
    e.b      = b;
    e.t      = cyc + LAT;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        repeat (baud / 4) @(negedge clk_50m);
        rst = 1'b1;
        rxd = 1'b1;
        return;
      end
      repeat (baud) @(negedge clk_50m);
    end
  endtask

  // Compare process: every event is matched against the model queue; holding-register rules checked each cycle.
  initial begin : compare
    logic       pv;
    logic [7:0] pd;
    logic       rdy_e;
    bit         load;
    ev_t        e;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(posedge clk_50m);
      #1;
      if (rst) begin
        pv = 1'b0;
        pd = '0;
        continue;
      end
      rdy_e = ready;
      load  = (valid && (!pv || rdy_e)) || overrun;
      if (overrun) n_ovr++;
      if (frame_err) n_ferr++;
      if (load || frame_err) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_event", cyc, 0);
        end else begin
          e = exp_q.pop_front();
          check("evt_is_frame_err", frame_err, e.is_err);
          if (!e.is_err) check("evt_data", data, e.b);
          check("evt_time_in_window", 32'(cyc >= e.t - 2 && cyc <= e.t + 2), 1);
          check("evt_overrun", overrun, pv && !rdy_e);
          evt_cyc.push_back(cyc);
        end
      end
      if (!load && pv && !rdy_e) begin
        check("hold_valid", valid, 1);
        check("hold_data", data, pd);
      end
      if (!load && pv && rdy_e) check("valid_clears_on_transfer", valid, 0);
      while (exp_q.size() > 0 && cyc > exp_q[0].t + 2) begin
        fail_now("event_missing", cyc, exp_q[0].t);
        void'(exp_q.pop_front());
      end
      pv = valid;
      pd = data;
    end
  end

  initial begin : stim
    int         n0, e0, f0, o0;
    logic [7:0] rb;
    int         rbaud;

    rst       = 1'b1;
    rxd       = 1'b1;
    ready_req = 1'b1;
    repeat (3) @(negedge clk_50m);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk_50m);

    // Single 0x55 frame at nominal rate.
    n0 = cyc; e0 = evt_cyc.size(); f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, CPB, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t1_event_count", evt_cyc.size() - e0, 1);
    if (evt_cyc.size() > e0)
      check("t1_latency_4126", 32'((evt_cyc[e0] - n0) >= 4125 && (evt_cyc[e0] - n0) <= 4127), 1);
    check("t1_data_55", data, 8'h55);
    check("t1_valid_low_after", valid, 0);
    check("t1_no_ferr", n_ferr - f0, 0);
    check("t1_no_overrun", n_ovr - o0, 0);

    // Back-to-back 0x00, 0xFF with no idle gap.
    e0 = evt_cyc.size();
    send_frame(8'h00, CPB, 1'b1, -1);
    send_frame(8'hFF, CPB, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t2_event_count", evt_cyc.size() - e0, 2);
    if (evt_cyc.size() > e0 + 1)
      check("t2_spacing_4340", evt_cyc[e0+1] - evt_cyc[e0], 4340);
    check("t2_data_ff", data, 8'hFF);

    // 100-cycle low glitch, then a real 0xA3 frame.
    e0 = evt_cyc.size(); f0 = n_ferr;
    rxd = 1'b0;
    repeat (100) @(negedge clk_50m);
    rxd = 1'b1;
    repeat (300) @(negedge clk_50m);
    check("t3_busy_back_low", busy, 0);
    check("t3_no_event", evt_cyc.size() - e0, 0);
    check("t3_no_ferr", n_ferr - f0, 0);
    send_frame(8'hA3, CPB, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t3_data_a3", data, 8'hA3);

    // Bad stop bit followed by a long break, then 0x81.
    e0 = evt_cyc.size(); f0 = n_ferr;
    send_frame(8'h3C, CPB, 1'b0, -1);
    repeat (20000) @(negedge clk_50m);
    check("t4_one_ferr", n_ferr - f0, 1);
    check("t4_one_event", evt_cyc.size() - e0, 1);
    check("t4_busy_in_break", busy, 1);
    check("t4_valid_low", valid, 0);
    check("t4_data_kept", data, 8'hA3);
    rxd = 1'b1;
    repeat (20) @(negedge clk_50m);
    check("t4_busy_released", busy, 0);
    send_frame(8'h81, CPB, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t4_data_81", data, 8'h81);
    check("t4_ferr_total", n_ferr - f0, 1);

    // Overrun with ready held low.
    ready_req = 1'b0;
    repeat (3) @(negedge clk_50m);
    o0 = n_ovr;
    send_frame(8'h12, CPB, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t5_valid_first", valid, 1);
    check("t5_data_12", data, 8'h12);
    check("t5_no_ovr_yet", n_ovr - o0, 0);
    send_frame(8'h34, CPB, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t5_valid_second", valid, 1);
    check("t5_data_34", data, 8'h34);
    check("t5_one_overrun", n_ovr - o0, 1);
    ready_req = 1'b1;
    @(negedge clk_50m);
    ready_req = 1'b0;
    @(negedge clk_50m);
    #3;
    check("t5_valid_consumed", valid, 0);
    ready_req = 1'b1;
    @(negedge clk_50m);

    // Reset during data bit 4, then 0xC7.
    e0 = evt_cyc.size();
    send_frame(8'hE1, CPB, 1'b1, 4);
    #1;
    check("t6_rst_data", data, 0);
    check("t6_rst_valid", valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ferr", frame_err, 0);
    check("t6_rst_ovr", overrun, 0);
    exp_q.delete();
    repeat (5) @(negedge clk_50m);
    rst = 1'b0;
    repeat (20) @(negedge clk_50m);
    check("t6_no_event", evt_cyc.size() - e0, 0);
    send_frame(8'hC7, CPB, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t6_data_c7", data, 8'hC7);

    // Baud tolerance at -2.3% and +2.3%.
    e0 = evt_cyc.size(); f0 = n_ferr;
    send_frame(8'h96, 424, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t7_data_96_fast", data, 8'h96);
    send_frame(8'h96, 444, 1'b1, -1);
    repeat (20) @(negedge clk_50m);
    check("t7_data_96_slow", data, 8'h96);
    check("t7_two_events", evt_cyc.size() - e0, 2);
    check("t7_no_ferr", n_ferr - f0, 0);

    // Random bytes, rates and consumer readiness.
    f0 = n_ferr; e0 = evt_cyc.size();
    rnd_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rb    = 8'($urandom);
      rbaud = $urandom_range(426, 442);
      send_frame(rb, rbaud, 1'b1, -1);
      repeat ($urandom_range(0, 30)) @(negedge clk_50m);
    end
    repeat (20) @(negedge clk_50m);
    rnd_ready = 1'b0;
    check("rnd_event_count", evt_cyc.size() - e0, 2);
    check("rnd_no_ferr", n_ferr - f0, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
